// File: rtl/c432_key_loader_if.sv
// Serial key-delivery bus between a key source and the c432 key loader.
// The master side shifts the key in; the slave side presents the verified key.
interface c432_key_loader_if #(
  parameter int KEY_W = 12
);
  logic             start;
  logic             clear;
  logic             key_valid;
  logic             key_bit;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_locked;
  logic             load_err;
  logic             dead;

  modport master (
    output start, clear, key_valid, key_bit,
    input  key_ready, key_out, key_locked, load_err, dead
  );

  modport slave (
    input  start, clear, key_valid, key_bit,
    output key_ready, key_out, key_locked, load_err, dead
  );
endinterface

// File: rtl/c432_key_loader.sv
// Loads the 12-bit c432 locking key serially, verifies even parity and only then
// releases it to the core; repeated failures lock the loader out until reset.
module c432_key_loader #(
  parameter int KEY_W    = 12,
  parameter int MAX_FAIL = 3,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  c432_key_loader_if.slave  bus
);

  localparam int                FAIL_W      = $clog2(MAX_FAIL + 1);
  localparam logic [CNT_W-1:0]  PARITY_BEAT = CNT_W'(KEY_W);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    LOCKED,
    DEAD
  } state_t;

  state_t            state;
  logic [KEY_W-1:0]  shadow;
  logic [KEY_W-1:0]  key_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic [FAIL_W-1:0] fail_cnt;
  logic              parity;
  logic              ready;
  logic              locked;
  logic              err;
  logic              dead_q;
  logic              beat;

  // Even parity over the key plus its parity beat.
  function automatic logic parity_ok(input logic [KEY_W-1:0] k, input logic p);
    return ~(^{k, p});
  endfunction

  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] f);
    return (f >= FAIL_LIMIT) ? FAIL_LIMIT : f + FAIL_W'(1);
  endfunction

  // ready is registered and high exactly while in SHIFT, so it doubles as the accept gate.
  assign beat = bus.key_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shadow   <= '0;
      key_q    <= '0;
      beat_cnt <= '0;
      fail_cnt <= '0;
      parity   <= 1'b0;
      ready    <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SHIFT;
            beat_cnt <= '0;
            shadow   <= '0;
            ready    <= 1'b1;
          end
        end

        SHIFT: begin
          if (bus.clear) begin
            // Abort wins over a same-cycle beat; the partial key is thrown away.
            state    <= IDLE;
            ready    <= 1'b0;
            shadow   <= '0;
            beat_cnt <= '0;
          end else if (beat) begin
            if (beat_cnt == PARITY_BEAT) begin
              parity <= bus.key_bit;
              state  <= CHECK;
              ready  <= 1'b0;
            end else begin
              for (int i = 0; i < KEY_W; i++) begin
                if (beat_cnt == CNT_W'(i)) shadow[i] <= bus.key_bit;
              end
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end

        CHECK: begin
          if (parity_ok(shadow, parity)) begin
            state    <= LOCKED;
            key_q    <= shadow;
            locked   <= 1'b1;
            fail_cnt <= '0;
          end else begin
            err      <= 1'b1;
            fail_cnt <= fail_inc(fail_cnt);
            if (fail_inc(fail_cnt) == FAIL_LIMIT) begin
              state  <= DEAD;
              dead_q <= 1'b1;
            end else begin
              state  <= IDLE;
            end
          end
        end

        LOCKED: begin
          if (bus.clear) begin
            state  <= IDLE;
            key_q  <= '0;
            locked <= 1'b0;
          end
        end

        DEAD: begin
          dead_q <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.key_ready  = ready;
  assign bus.key_out    = key_q;
  assign bus.key_locked = locked;
  assign bus.load_err   = err;
  assign bus.dead       = dead_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Self-checking bench for c432_key_loader: directed scenarios plus randomized loads
// compared against a transaction-level model of lock / fail / lockout behaviour.
module tb_c432_key_loader;
  localparam int KEY_W    = 12;
  localparam int MAX_FAIL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c432_key_loader_if #(.KEY_W(KEY_W)) bus ();

  c432_key_loader #(
    .KEY_W   (KEY_W),
    .MAX_FAIL(MAX_FAIL),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level reference state
  logic [KEY_W-1:0] m_key;
  bit               m_locked;
  bit               m_dead;
  int               m_fail;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.clear     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
  endtask

  task automatic model_reset();
    m_key    = '0;
    m_locked = 1'b0;
    m_dead   = 1'b0;
    m_fail   = 0;
  endtask

  // A completed load either locks (parity even) or counts one more failure.
  task automatic model_load(input logic [KEY_W-1:0] k, input logic par);
    int ones;
    ones = par;
    for (int i = 0; i < KEY_W; i++) ones += k[i];
    if (ones % 2 == 0) begin
      m_key    = k;
      m_locked = 1'b1;
      m_fail   = 0;
    end else begin
      m_fail = m_fail + 1;
      if (m_fail >= MAX_FAIL) begin
        m_fail = MAX_FAIL;
        m_dead = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    if (m_locked) begin
      m_locked = 1'b0;
      m_key    = '0;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    model_reset();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_clear();
  endtask

  // gaps: 0 none, 1 stall before every beat, 2 random stalls.
  // Returns just after the edge that accepted the parity beat.
  task automatic drive_load(input logic [KEY_W-1:0] k, input logic par, input int gaps,
                            output bit leaked, output bit ready_ok, output bit err_seen);
    leaked   = 1'b0;
    ready_ok = 1'b1;
    err_seen = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i <= KEY_W; i++) begin
      if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
        bus.key_valid = 1'b0;
        step();
        if (bus.key_out !== '0 || bus.key_locked !== 1'b0) leaked = 1'b1;
        if (bus.load_err) err_seen = 1'b1;
      end
      if (bus.key_ready !== 1'b1) ready_ok = 1'b0;
      bus.key_valid = 1'b1;
      bus.key_bit   = (i < KEY_W) ? k[i] : par;
      step();
      if (bus.key_out !== '0 || bus.key_locked !== 1'b0) leaked = 1'b1;
      if (bus.load_err) err_seen = 1'b1;
    end
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.key_ready, bus.key_out, bus.key_locked, bus.load_err, bus.dead} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got ready=%b key=%h lock=%b err=%b dead=%b want all 0",
               bus.key_ready, bus.key_out, bus.key_locked, bus.load_err, bus.dead);
    end
    rst_n = 1'b1;
    step();
    model_reset();
    n_cmp++;
    if (bus.key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ready got %b want 0", bus.key_ready);
    end
  endtask

  task automatic test_clean_load();
    bit leaked, rdy, errs;
    drive_load(12'hA5C, 1'b0, 0, leaked, rdy, errs);
    model_load(12'hA5C, 1'b0);
    n_cmp++;
    if (rdy !== 1'b1 || leaked !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_shift got ready_ok=%b leaked=%b want 1 0", rdy, leaked);
    end
    n_cmp++;
    if (bus.key_locked !== 1'b0 || bus.key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_check_cycle got lock=%b ready=%b want 0 0", bus.key_locked, bus.key_ready);
    end
    step();
    n_cmp++;
    if (bus.key_locked !== 1'b1 || bus.key_out !== m_key) begin
      n_bad++;
      $display("FAIL clean_lock got lock=%b key=%h want 1 %h", bus.key_locked, bus.key_out, m_key);
    end
    n_cmp++;
    if (bus.load_err !== 1'b0 || errs !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_no_err got err=%b seen=%b want 0 0", bus.load_err, errs);
    end
    // start is ignored while locked
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    n_cmp++;
    if (bus.key_ready !== 1'b0 || bus.key_out !== 12'hA5C) begin
      n_bad++;
      $display("FAIL locked_start_ignored got ready=%b key=%h want 0 a5c", bus.key_ready, bus.key_out);
    end
    do_clear();
  endtask

  task automatic test_stall_load();
    bit leaked, rdy, errs;
    drive_load(12'hA5C, 1'b0, 1, leaked, rdy, errs);
    model_load(12'hA5C, 1'b0);
    n_cmp++;
    if (leaked !== 1'b0 || rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_no_leak got leaked=%b ready_ok=%b want 0 1", leaked, rdy);
    end
    step();
    n_cmp++;
    if (bus.key_locked !== 1'b1 || bus.key_out !== 12'hA5C || bus.load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_lock got lock=%b key=%h err=%b want 1 a5c 0",
               bus.key_locked, bus.key_out, bus.load_err);
    end
    do_clear();
  endtask

  task automatic test_bad_parity();
    bit leaked, rdy, errs;
    drive_load(12'hA5C, 1'b1, 0, leaked, rdy, errs);
    model_load(12'hA5C, 1'b1);
    step();
    n_cmp++;
    if (bus.load_err !== 1'b1 || bus.key_locked !== 1'b0 || bus.key_out !== '0) begin
      n_bad++;
      $display("FAIL bad_err_pulse got err=%b lock=%b key=%h want 1 0 000",
               bus.load_err, bus.key_locked, bus.key_out);
    end
    step();
    n_cmp++;
    if (bus.load_err !== 1'b0 || bus.key_ready !== 1'b0 || bus.dead !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_err_one_cycle got err=%b ready=%b dead=%b want 0 0 0",
               bus.load_err, bus.key_ready, bus.dead);
    end
    drive_load(12'hA5C, 1'b0, 0, leaked, rdy, errs);
    model_load(12'hA5C, 1'b0);
    step();
    n_cmp++;
    if (bus.key_locked !== 1'b1 || bus.key_out !== 12'hA5C) begin
      n_bad++;
      $display("FAIL bad_then_good got lock=%b key=%h want 1 a5c", bus.key_locked, bus.key_out);
    end
    do_clear();
    // Two more failures must not kill the loader if the good load zeroed the count
    for (int n = 0; n < 2; n++) begin
      drive_load(12'h001, 1'b0, 0, leaked, rdy, errs);
      model_load(12'h001, 1'b0);
      step();
      step();
    end
    n_cmp++;
    if (bus.dead !== m_dead) begin
      n_bad++;
      $display("FAIL fail_cnt_reset got dead=%b want %b", bus.dead, m_dead);
    end
    drive_load(12'h3F0, 1'b0, 0, leaked, rdy, errs);
    model_load(12'h3F0, 1'b0);
    step();
    do_clear();
  endtask

  task automatic test_dead();
    bit leaked, rdy, errs;
    bit ok;
    for (int n = 0; n < MAX_FAIL; n++) begin
      drive_load(12'hA5C, 1'b1, 0, leaked, rdy, errs);
      model_load(12'hA5C, 1'b1);
      step();
      if (n < MAX_FAIL - 1) step();
    end
    n_cmp++;
    if (bus.dead !== 1'b1 || bus.load_err !== 1'b1 || m_dead !== 1'b1) begin
      n_bad++;
      $display("FAIL dead_entry got dead=%b err=%b want 1 1", bus.dead, bus.load_err);
    end
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.clear     = 1'($urandom_range(0, 1));
      bus.key_valid = 1'($urandom_range(0, 1));
      bus.key_bit   = 1'($urandom_range(0, 1));
      step();
      if (bus.dead !== 1'b1 || bus.key_ready !== 1'b0 || bus.key_out !== '0 ||
          bus.key_locked !== 1'b0)
        ok = 1'b0;
    end
    idle_inputs();
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL dead_sticky got ok=%b dead=%b want 1 1", ok, bus.dead);
    end
    apply_reset();
    n_cmp++;
    if (bus.dead !== 1'b0) begin
      n_bad++;
      $display("FAIL dead_reset got %b want 0", bus.dead);
    end
    drive_load(12'h3F0, 1'b0, 0, leaked, rdy, errs);
    model_load(12'h3F0, 1'b0);
    step();
    n_cmp++;
    if (bus.key_locked !== 1'b1 || bus.key_out !== 12'h3F0) begin
      n_bad++;
      $display("FAIL dead_recover got lock=%b key=%h want 1 3f0", bus.key_locked, bus.key_out);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    bit leaked, rdy, errs;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'($urandom_range(0, 1));
      step();
    end
    n_cmp++;
    if (bus.key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_pre_ready got %b want 1", bus.key_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.key_ready, bus.key_out, bus.key_locked, bus.load_err, bus.dead} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got ready=%b key=%h lock=%b want all 0",
               bus.key_ready, bus.key_out, bus.key_locked);
    end
    idle_inputs();
    #2;
    rst_n = 1'b1;
    model_reset();
    step();
    drive_load(12'h3F0, 1'b0, 0, leaked, rdy, errs);
    model_load(12'h3F0, 1'b0);
    step();
    n_cmp++;
    if (bus.key_locked !== 1'b1 || bus.key_out !== 12'h3F0) begin
      n_bad++;
      $display("FAIL async_reload got lock=%b key=%h want 1 3f0", bus.key_locked, bus.key_out);
    end
    do_clear();
  endtask

  task automatic test_clear();
    bit leaked, rdy, errs;
    // clear in IDLE has no effect on a subsequent load
    do_clear();
    drive_load(12'hA5C, 1'b0, 0, leaked, rdy, errs);
    model_load(12'hA5C, 1'b0);
    step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_clear();
    n_cmp++;
    if (bus.key_out !== '0 || bus.key_locked !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_locked got key=%h lock=%b want 000 0", bus.key_out, bus.key_locked);
    end
    for (int n = 0; n < MAX_FAIL - 1; n++) begin
      drive_load(12'h800, 1'b0, 0, leaked, rdy, errs);
      model_load(12'h800, 1'b0);
      step();
      step();
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'b1;
      step();
    end
    bus.clear = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.key_ready !== 1'b0 || bus.dead !== 1'b0 || bus.load_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_shift got ready=%b dead=%b err=%b want 0 0 0",
               bus.key_ready, bus.dead, bus.load_err);
    end
    // fail count kept across the abort: one more failure reaches the limit
    drive_load(12'h800, 1'b0, 0, leaked, rdy, errs);
    model_load(12'h800, 1'b0);
    step();
    n_cmp++;
    if (bus.dead !== m_dead || m_dead !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_keeps_fail got dead=%b want 1", bus.dead);
    end
    apply_reset();
  endtask

  task automatic test_random();
    bit leaked, rdy, errs;
    logic [KEY_W-1:0] k;
    logic par;
    int   gaps;
    bit   exp_err;
    bit   was_dead;
    for (int n = 0; n < 40; n++) begin
      if (m_dead) apply_reset();
      if (m_locked) do_clear();
      if ($urandom_range(0, 3) == 0) do_clear();
      k    = KEY_W'($urandom);
      par  = (^k) ^ ($urandom_range(0, 3) == 0);
      gaps = $urandom_range(0, 2);
      was_dead = m_dead;
      drive_load(k, par, gaps, leaked, rdy, errs);
      model_load(k, par);
      exp_err = !m_locked && !was_dead;
      step();
      n_cmp++;
      if (bus.key_locked !== m_locked || bus.key_out !== m_key || bus.load_err !== exp_err ||
          bus.dead !== m_dead || leaked !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_load[%0d] got lock=%b key=%h err=%b dead=%b leak=%b want %b %h %b %b 0",
                 n, bus.key_locked, bus.key_out, bus.load_err, bus.dead, leaked,
                 m_locked, m_key, exp_err, m_dead);
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_clean_load();
    test_stall_load();
    test_bad_parity();
    test_dead();
    test_async_reset();
    test_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout after 400000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/c432_key_loader.md
Name: c432_key_loader

Overview:
- Upstream key-delivery stage for the key-locked c432 core. It drives the core's 4 mux-select key inputs (p1..p4) and 8 XOR key inputs (X_1..X_8).
- Receives the 12-bit key serially with a valid/ready handshake, then checks an even-parity bit. It releases the key to the core only after a clean load.
- Counts failed loads and disables itself permanently after too many failures, until the next reset.
- While not locked, the key outputs hold all-zero, so the core computes a wrong function.

Parameters:
- KEY_W, 12, key width. Bits 3:0 map to p1..p4 (bit0=p1). Bits 11:4 map to X_1..X_8 (bit4=X_1).
- MAX_FAIL, 3, number of consecutive failed loads that forces the DEAD state.
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > KEY_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a key load.
- clear  in  1  abort a load, or drop the key, and return to IDLE.
- key_valid  in  1  serial bit valid.
- key_bit  in  1  serial data. LSB first, KEY_W key beats followed by 1 parity beat.
- key_ready  out  1  high only in SHIFT.
- key_out  out  KEY_W  key bus to the core, {X_8..X_1, p4..p1}.
- key_locked  out  1  key_out holds a verified key.
- load_err  out  1  one-cycle pulse on a parity failure.
- dead  out  1  permanent lockout flag, cleared only by rst_n.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, key_out=0, shadow=0, beat_cnt=0, fail_cnt=0, all flags 0. Reset asserted at any time, including mid-shift, returns everything to these values immediately.
- IDLE:
  - start=1 -> SHIFT on the next cycle; beat_cnt and shadow are cleared.
  - clear in IDLE has no effect.
- SHIFT:
  - key_ready=1. A beat is accepted only on key_valid & key_ready; key_valid=0 cycles stall with no state change.
  - Beats 0..KEY_W-1 are written to shadow[beat_cnt].
  - Beat KEY_W is the parity bit. It is captured, and the state moves to CHECK on the next cycle.
  - start is ignored in SHIFT.
  - clear -> IDLE. Shadow is discarded and fail_cnt is unchanged.
  - If clear and a beat arrive in the same cycle, clear wins and the beat is dropped.
- CHECK (one cycle, key_ready=0):
  - Pass condition: XOR of shadow and the parity bit equals 0 (even parity).
  - Pass -> LOCKED. key_out<=shadow, key_locked<=1, fail_cnt<=0.
  - Fail -> load_err pulses for 1 cycle and fail_cnt increments. If the new fail_cnt equals MAX_FAIL the state goes to DEAD, otherwise to IDLE.
  - clear is ignored in CHECK.
- Latency: if the parity beat is accepted in cycle t, the state is CHECK in cycle t+1. key_locked and key_out are valid, or load_err is high, in cycle t+2.
- LOCKED:
  - key_out is stable and start is ignored.
  - clear -> IDLE, with key_out<=0 and key_locked<=0 on the same edge.
- DEAD:
  - dead=1, key_ready=0, key_out=0. start and clear are ignored. Only rst_n exits.
- key_out changes only on entry to LOCKED, or to 0 on exit from LOCKED. It never exposes a partially loaded shadow.
- fail_cnt saturates at MAX_FAIL. It is not reset by clear.

Test Plan:
1. Reset, start, then 12 beats of 12'hA5C LSB-first plus parity 0, with no gaps -> key_locked=1 and key_out=12'hA5C two cycles after the parity beat; load_err never asserts.
2. Same load with key_valid low on alternate cycles -> identical result, with locking delayed only by the stall cycles; key_out remains 0 until the lock edge.
3. Load 12'hA5C with parity 1 -> load_err pulses one cycle, state returns to IDLE, key_out=0; a following correct load locks and resets fail_cnt.
4. Three consecutive bad-parity loads with MAX_FAIL=3 -> dead=1 after the third; start and clear are ignored for 20 cycles; rst_n low then high -> dead=0 and a load succeeds.
5. Assert rst_n low after 5 beats -> key_ready=0 and all outputs are 0 asynchronously; the next full load of 12'h3F0 with parity 0 locks normally.
6. Locked at 12'hA5C, then clear=1 -> key_out=0 and key_locked=0 the next cycle; clear asserted together with a beat during SHIFT -> IDLE with the beat dropped and fail_cnt unchanged.
